fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Top-level instruction sequencer for the RISC CPU. Fetches each 16-bit instruction from synchronous RAM into the IR,
//  advances the PC, decodes the opcode and hands execution to the datapath controller via a start/waiting handshake.
//  Owns LDR/STR memory sequencing, HALT, illegal-opcode and execute-timeout faults, and a retired-instruction counter.
// PARAMETERS
//  EXE_TIMEOUT  15  max cycles in EXE_WAIT without exe_waiting before FAULT (>=2)
//  CNT_W        16  width of instr_count
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  opcode       in   3      IR[15:13]
//  op           in   2      IR[12:11]
//  exe_waiting  in   1      controller idle/done flag
//  exe_start    out  1      one-cycle start pulse to controller
//  exe_phase    out  2      micro-op for controller: 00 NORMAL, 01 ADDR (C=Rn+sximm5), 10 LDWB (Rd<=mdata), 11 STRD (C=Rd)
//  reset_pc     out  1      PC mux selects 0
//  load_pc      out  1      PC register enable
//  load_ir      out  1      IR enable
//  load_addr    out  1      data-address register enable (from C)
//  addr_sel     out  1      1: mem_addr=PC, 0: mem_addr=data address
//  mem_cmd      out  2      00 NONE, 01 READ, 10 WRITE
//  halted       out  1      HALT executed
//  fault        out  1      sequencer stopped on error
//  fault_cause  out  2      00 none, 01 illegal opcode, 10 execute timeout
//  instr_count  out  CNT_W  retired instructions, wraps at 2^CNT_W
// BEHAVIOUR
//  - Moore outputs decoded from state; exe_phase from a register loaded in DECODE/phase transitions.
//  - Reset (rst_n=0, any time, mid-instruction included): state=RESET, instr_count=0, fault_cause=00, watchdog=0.
//    RESET outputs: reset_pc=1, load_pc=1; all others 0, mem_cmd=NONE.
//  - RESET -> IF1 on first edge with rst_n=1.
//  - IF1: addr_sel=1, mem_cmd=READ -> IF2 (1-cycle RAM latency).
//  - IF2: addr_sel=1, mem_cmd=READ, load_ir=1 -> UPDATE_PC.
//  - UPDATE_PC: load_pc=1 (PC+1) -> DECODE.
//  - DECODE (opcode,op): 110/101 any op -> EXE_ISSUE phase NORMAL; 011/00 LDR, 100/00 STR -> EXE_ISSUE phase ADDR;
//    111 -> HALT; anything else (incl. 011/100 with op!=00) -> FAULT cause 01.
//  - EXE_ISSUE: exe_start=1 for exactly one cycle -> EXE_WAIT; watchdog cleared.
//  - EXE_WAIT: exe_waiting ignored in its first cycle (controller leaves wait on the start edge); from the 2nd cycle,
//    exe_waiting=1 completes the phase. Watchdog counts each EXE_WAIT cycle; reaching EXE_TIMEOUT with no completion
//    -> FAULT cause 10 (completion in the same cycle wins).
//  - Phase completion: NORMAL -> retire, IF1. ADDR -> MEM_ADDR. LDWB -> retire, IF1. STRD -> MEM_WR.
//  - MEM_ADDR: load_addr=1; LDR -> MEM_RD1, STR -> EXE_ISSUE phase STRD.
//  - MEM_RD1 / MEM_RD2: addr_sel=0, mem_cmd=READ; MEM_RD2 -> EXE_ISSUE phase LDWB.
//  - MEM_WR: addr_sel=0, mem_cmd=WRITE for exactly one cycle -> retire, IF1.
//  - Retire: instr_count+1 on the transition edge into IF1; wraps to 0. HALT/faulting instructions not counted.
//  - HALT: halted=1, all enables 0, mem_cmd=NONE; absorbing until reset. FAULT: fault=1, same quiescence, absorbing.
//  - Never load_pc and load_ir in the same cycle; mem_cmd=WRITE only in MEM_WR.
//  - Latency (fetch start to next fetch): NORMAL = 3 + 1 + 1 + N_exe; LDR adds MEM_ADDR + 2 read + 2nd exec; STR adds
//    MEM_ADDR + 2nd exec + 1 write.
// STRUCTURE
//  - cpu_pkg: seq_state_t enum, opcode constants (OPC_MOV=110, OPC_ALU=101, OPC_LDR=011, OPC_STR=100, OPC_HLT=111),
//    mem_cmd_t, exe_phase_t, fault_cause_t.
//  - One sub-module: seq_watchdog (clear, count enable, EXE_TIMEOUT compare -> expired); rest is one FSM + counter.
// TESTING
//  - Reset then idle controller model (1-cycle exec): IR=110_10_000_00000101 -> IF1,IF2,UPDATE_PC,DECODE,ISSUE,WAIT,
//    instr_count 0->1, exe_phase=00, exactly one exe_start pulse.
//  - LDR (011_00): phases ADDR then LDWB; load_addr=1 once; two READ cycles with addr_sel=0; no WRITE; count+1.
//  - STR (100_00): phases ADDR then STRD; mem_cmd=WRITE exactly 1 cycle with addr_sel=0, after STRD completion; count+1.
//  - HALT (111) after 3 ALU ops -> halted=1, instr_count=3, outputs quiescent 20 cycles; rst_n pulse -> RESET, count=0.
//  - Opcode 000 -> fault=1, cause=01; controller holding exe_waiting=0 -> FAULT cause 10 after EXE_TIMEOUT=15 cycles;
//    exe_waiting rising on cycle 15 -> completes, no fault.
//  - rst_n asserted mid-MEM_RD1 and mid-EXE_WAIT -> immediate RESET outputs (reset_pc=load_pc=1, mem_cmd=NONE), then refetch from PC 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch/execute sequencer.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_RESET,
        S_IF1,
        S_IF2,
        S_UPDATE_PC,
        S_DECODE,
        S_EXE_ISSUE,
        S_EXE_WAIT,
        S_MEM_ADDR,
        S_MEM_RD1,
        S_MEM_RD2,
        S_MEM_WR,
        S_HALT,
        S_FAULT
    } seq_state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [2:0] OPC_LDR = 3'b011;
    localparam logic [2:0] OPC_STR = 3'b100;
    localparam logic [2:0] OPC_HLT = 3'b111;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } mem_cmd_t;

    typedef enum logic [1:0] {
        PH_NORMAL = 2'b00,
        PH_ADDR   = 2'b01,
        PH_LDWB   = 2'b10,
        PH_STRD   = 2'b11
    } exe_phase_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_ILLEGAL = 2'b01,
        FC_TIMEOUT = 2'b10
    } fault_cause_t;

endpackage

// File: rtl/seq_watchdog.sv
// Execute-phase watchdog: down-counter loaded on clear, decremented once per
// wait cycle, expired at terminal count zero. first_cycle marks the first wait
// cycle, where the controller's waiting flag is still stale.
module seq_watchdog #(
    parameter int unsigned EXE_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic first_cycle,
    output logic expired
);

    localparam int unsigned     WD_W    = $clog2(EXE_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(EXE_TIMEOUT - 1);

    logic [WD_W-1:0] cnt_q;

    // Load on clear, count down while enabled, hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= WD_LOAD;
        end else if (count_en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign first_cycle = (cnt_q == WD_LOAD);
    assign expired     = (cnt_q == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode sequencer with memory-op sequencing, halt/fault
// handling and a retired-instruction counter.
//
//  state       | meaning
//  ------------+---------------------------------------------------
//  RESET       | PC forced to 0
//  IF1         | read RAM at PC (1-cycle latency)
//  IF2         | read data valid, load IR
//  UPDATE_PC   | PC <= PC + 1
//  DECODE      | classify opcode, pick first execute phase
//  EXE_ISSUE   | one-cycle start pulse to datapath controller
//  EXE_WAIT    | wait for controller done, watchdog running
//  MEM_ADDR    | capture data address from C
//  MEM_RD1/2   | data read at data address
//  MEM_WR      | single write cycle at data address
//  HALT        | HALT executed, quiescent until reset
//  FAULT       | illegal opcode or execute timeout, quiescent
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned EXE_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       opcode,
    input  logic [1:0]       op,
    input  logic             exe_waiting,
    output logic             exe_start,
    output logic [1:0]       exe_phase,
    output logic             reset_pc,
    output logic             load_pc,
    output logic             load_ir,
    output logic             load_addr,
    output logic             addr_sel,
    output logic [1:0]       mem_cmd,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [CNT_W-1:0] instr_count
);

    seq_state_t   state_q, state_d;
    exe_phase_t   phase_q, phase_d;
    fault_cause_t cause_q, cause_d;
    logic         store_q, store_d;
    logic         retire;
    logic         wd_first, wd_expired;
    logic [CNT_W-1:0] count_q;

    seq_watchdog #(
        .EXE_TIMEOUT(EXE_TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state_q == S_EXE_ISSUE),
        .count_en   (state_q == S_EXE_WAIT),
        .first_cycle(wd_first),
        .expired    (wd_expired)
    );

    // State register plus the per-instruction context captured alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            phase_q <= PH_NORMAL;
            cause_q <= FC_NONE;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cause_q <= cause_d;
            store_q <= store_d;
        end
    end

    // Next-state, phase selection, fault cause and retire decision.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cause_d = cause_q;
        store_d = store_q;
        retire  = 1'b0;
        case (state_q)
            S_RESET:     state_d = S_IF1;
            S_IF1:       state_d = S_IF2;
            S_IF2:       state_d = S_UPDATE_PC;
            S_UPDATE_PC: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OPC_MOV, OPC_ALU: begin
                        state_d = S_EXE_ISSUE;
                        phase_d = PH_NORMAL;
                    end
                    OPC_LDR, OPC_STR: begin
                        if (op == 2'b00) begin
                            state_d = S_EXE_ISSUE;
                            phase_d = PH_ADDR;
                            store_d = (opcode == OPC_STR);
                        end else begin
                            state_d = S_FAULT;
                            cause_d = FC_ILLEGAL;
                        end
                    end
                    OPC_HLT: state_d = S_HALT;
                    default: begin
                        state_d = S_FAULT;
                        cause_d = FC_ILLEGAL;
                    end
                endcase
            end
            S_EXE_ISSUE: state_d = S_EXE_WAIT;
            S_EXE_WAIT: begin
                // Completion is checked before expiry so a done flag on the
                // last allowed cycle still wins.
                if (exe_waiting && !wd_first) begin
                    case (phase_q)
                        PH_NORMAL, PH_LDWB: begin
                            state_d = S_IF1;
                            retire  = 1'b1;
                        end
                        PH_ADDR: state_d = S_MEM_ADDR;
                        PH_STRD: state_d = S_MEM_WR;
                        default: state_d = S_FAULT;
                    endcase
                end else if (wd_expired) begin
                    state_d = S_FAULT;
                    cause_d = FC_TIMEOUT;
                end
            end
            S_MEM_ADDR: begin
                if (store_q) begin
                    state_d = S_EXE_ISSUE;
                    phase_d = PH_STRD;
                end else begin
                    state_d = S_MEM_RD1;
                end
            end
            S_MEM_RD1: state_d = S_MEM_RD2;
            S_MEM_RD2: begin
                state_d = S_EXE_ISSUE;
                phase_d = PH_LDWB;
            end
            S_MEM_WR: begin
                state_d = S_IF1;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    // Moore output decode.
    always_comb begin
        reset_pc  = 1'b0;
        load_pc   = 1'b0;
        load_ir   = 1'b0;
        load_addr = 1'b0;
        addr_sel  = 1'b0;
        mem_cmd   = MEM_NONE;
        exe_start = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        case (state_q)
            S_RESET: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
            end
            S_IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_READ;
            end
            S_IF2: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_READ;
                load_ir  = 1'b1;
            end
            S_UPDATE_PC: load_pc   = 1'b1;
            S_EXE_ISSUE: exe_start = 1'b1;
            S_MEM_ADDR:  load_addr = 1'b1;
            S_MEM_RD1, S_MEM_RD2: mem_cmd = MEM_READ;
            S_MEM_WR:    mem_cmd   = MEM_WRITE;
            S_HALT:      halted    = 1'b1;
            S_FAULT:     fault     = 1'b1;
            default: ;
        endcase
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign exe_phase   = phase_q;
    assign fault_cause = cause_q;
    assign instr_count = count_q;

endmodule
